// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and the
// "no register" marker used by the pipeline stages.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] SAOK = 4'h1;
    localparam logic [3:0] SHLT = 4'h2;
    localparam logic [3:0] SADR = 4'h4;
    localparam logic [3:0] SINS = 4'h8;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic {
        MS_IDLE,
        MS_BUSY
    } mstate_t;

    // Loads that take their address from valA (stack pops).
    function automatic logic rd_uses_vala(input logic [3:0] icode);
        return (icode == IRET) || (icode == IPOPQ);
    endfunction

endpackage

// File: rtl/mem_stage_param_dmem_array.sv
// Word-addressed data memory: synchronous write, combinational read.
// Ports: clk, we, addr, wdata in; rdata, in_range (addr < DEPTH) out.
module dmem_array #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              we,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              in_range
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W-1:0] LIMIT = DATA_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     idx;

    assign idx      = addr[AW-1:0];
    assign in_range = (addr < LIMIT);

    // Out-of-range addresses never index the array.
    assign rdata = in_range ? mem[idx] : '0;

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/mem_stage_param.sv
// Y86-64 memory stage: data memory access with optional wait states,
// m_valM/m_stat forwarding and the W pipeline register.
// Ports: clk, rst (sync, active high); M_* from M register; W_stall,
// W_bubble from hazard control; m_stall, m_valM, m_stat forwarding;
// W_stat/W_icode/W_valE/W_valM/W_dstE/W_dstM W register outputs.
module mem_stage_param
    import y86_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        M_stat,
    input  logic [3:0]        M_icode,
    input  logic              M_cnd,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] M_valA,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic              W_stall,
    input  logic              W_bubble,
    output logic              m_stall,
    output logic [DATA_W-1:0] m_valM,
    output logic [3:0]        m_stat,
    output logic [3:0]        W_stat,
    output logic [3:0]        W_icode,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM
);

    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    localparam int CW = HAS_WAIT ? $clog2(WAIT_CYCLES + 1) : 1;
    // Counter holds the stall cycles left after the current one, so the
    // start cycle plus the BUSY cycles give exactly WAIT_CYCLES of stall.
    localparam logic [CW-1:0] CNT_LOAD =
        HAS_WAIT ? CW'(WAIT_CYCLES - 1) : '0;

    logic              is_rd;
    logic              is_wr;
    logic              acc;
    logic              ok;
    logic              err;
    logic              start;
    logic              we;
    logic              hit;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] rdata;
    mstate_t           state;
    logic [CW-1:0]     cnt;

    // Branch outcome is irrelevant to memory access.
    logic unused_cnd;
    assign unused_cnd = M_cnd;

    always_comb begin
        is_rd = 1'b0;
        is_wr = 1'b0;
        unique case (M_icode)
            IMRMOVQ, IRET, IPOPQ:   is_rd = 1'b1;
            IRMMOVQ, ICALL, IPUSHQ: is_wr = 1'b1;
            default: ;
        endcase
    end

    assign addr  = rd_uses_vala(M_icode) ? M_valA : M_valE;
    assign acc   = (is_rd || is_wr) && (M_stat == SAOK);
    assign ok    = acc && hit;
    assign err   = acc && !hit;
    assign start = HAS_WAIT && ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MS_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                MS_IDLE: begin
                    if (start) begin
                        state <= MS_BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                MS_BUSY: begin
                    if (cnt == '0) begin
                        state <= MS_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    assign m_stall = (state == MS_IDLE) ? start : (cnt != '0);

    // Reset in the completing cycle must not let the store through.
    assign we = ok && is_wr && !m_stall && !rst;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dmem (
        .clk      (clk),
        .we       (we),
        .addr     (addr),
        .wdata    (M_valA),
        .rdata    (rdata),
        .in_range (hit)
    );

    assign m_valM = (ok && is_rd && !m_stall) ? rdata : '0;
    assign m_stat = err ? SADR : M_stat;

    always_ff @(posedge clk) begin
        if (rst) begin
            W_stat  <= SAOK;
            W_icode <= INOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else if (W_stall) begin
            W_stat  <= W_stat;
            W_icode <= W_icode;
            W_valE  <= W_valE;
            W_valM  <= W_valM;
            W_dstE  <= W_dstE;
            W_dstM  <= W_dstM;
        end else if (W_bubble || m_stall) begin
            W_stat  <= SAOK;
            W_icode <= INOP;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else begin
            W_stat  <= m_stat;
            W_icode <= M_icode;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            W_dstE  <= M_dstE;
            W_dstM  <= M_dstM;
        end
    end

endmodule

// File: tb/tb_mem_stage_param.sv
// Directed scoreboard bench for mem_stage_param with three instances
// (WAIT_CYCLES 0, 2, 3) sharing one stimulus bundle.
module tb_mem_stage_param;
    import y86_pkg::*;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    M_stat, M_icode, M_dstE, M_dstM;
    logic          M_cnd;
    logic [DW-1:0] M_valE, M_valA;
    logic          W_stall, W_bubble;

    logic          stl [3];
    logic [DW-1:0] valm [3];
    logic [3:0]    mst [3];
    logic [3:0]    ws [3], wi [3], wde [3], wdm [3];
    logic [DW-1:0] wve [3], wvm [3];

    always #5 clk = ~clk;

    mem_stage_param #(.DATA_W(DW), .DEPTH(1024), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .M_stat(M_stat), .M_icode(M_icode),
        .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall),
        .W_bubble(W_bubble), .m_stall(stl[0]), .m_valM(valm[0]),
        .m_stat(mst[0]), .W_stat(ws[0]), .W_icode(wi[0]),
        .W_valE(wve[0]), .W_valM(wvm[0]), .W_dstE(wde[0]),
        .W_dstM(wdm[0]));

    mem_stage_param #(.DATA_W(DW), .DEPTH(1024), .WAIT_CYCLES(2)) u1 (
        .clk(clk), .rst(rst), .M_stat(M_stat), .M_icode(M_icode),
        .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall),
        .W_bubble(W_bubble), .m_stall(stl[1]), .m_valM(valm[1]),
        .m_stat(mst[1]), .W_stat(ws[1]), .W_icode(wi[1]),
        .W_valE(wve[1]), .W_valM(wvm[1]), .W_dstE(wde[1]),
        .W_dstM(wdm[1]));

    mem_stage_param #(.DATA_W(DW), .DEPTH(1024), .WAIT_CYCLES(3)) u2 (
        .clk(clk), .rst(rst), .M_stat(M_stat), .M_icode(M_icode),
        .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall),
        .W_bubble(W_bubble), .m_stall(stl[2]), .m_valM(valm[2]),
        .m_stat(mst[2]), .W_stat(ws[2]), .W_icode(wi[2]),
        .W_valE(wve[2]), .W_valM(wvm[2]), .W_dstE(wde[2]),
        .W_dstM(wdm[2]));

    typedef struct packed {
        logic [3:0]    st;
        logic [3:0]    ic;
        logic [DW-1:0] ve;
        logic [DW-1:0] vm;
        logic [3:0]    de;
        logic [3:0]    dm;
    } w_t;

    w_t q[$];
    int n_chk = 0;
    int n_fail = 0;

    function automatic w_t mk(logic [3:0] st, logic [3:0] ic,
                              logic [DW-1:0] ve, logic [DW-1:0] vm,
                              logic [3:0] de, logic [3:0] dm);
        w_t w;
        w.st = st; w.ic = ic; w.ve = ve;
        w.vm = vm; w.de = de; w.dm = dm;
        return w;
    endfunction

    function automatic w_t bub();
        return mk(SAOK, INOP, '0, '0, RNONE, RNONE);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic [3:0] st, logic [3:0] ic,
                         logic [DW-1:0] ve, logic [DW-1:0] va,
                         logic [3:0] de, logic [3:0] dm);
        M_stat = st; M_icode = ic; M_valE = ve;
        M_valA = va; M_dstE = de; M_dstM = dm;
    endtask

    // Advance one edge and compare dut d's W register with the next
    // scoreboard entry.
    task automatic tick(int d);
        w_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("sb_underflow", 64'(q.size()), 64'd1);
        end else begin
            e = q.pop_front();
            chk("W_stat",  64'(ws[d]),  64'(e.st));
            chk("W_icode", 64'(wi[d]),  64'(e.ic));
            chk("W_valE",  wve[d],      e.ve);
            chk("W_valM",  wvm[d],      e.vm);
            chk("W_dstE",  64'(wde[d]), 64'(e.de));
            chk("W_dstM",  64'(wdm[d]), 64'(e.dm));
        end
    endtask

    task automatic do_reset(int d);
        rst = 1'b1;
        drive(SAOK, INOP, '0, '0, RNONE, RNONE);
        q.push_back(bub());
        tick(d);
        chk("rst_stall", 64'(stl[d]), 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        M_cnd = 1'b0;
        W_stall = 1'b0;
        W_bubble = 1'b0;

        // ---------------- WAIT_CYCLES = 0 ----------------
        do_reset(0);
        chk("rst_stall1", 64'(stl[1]), 64'd0);
        chk("rst_stall2", 64'(stl[2]), 64'd0);

        drive(SAOK, IRMMOVQ, 64'd16, 64'hDEAD, RNONE, RNONE);
        q.push_back(mk(SAOK, IRMMOVQ, 64'd16, '0, RNONE, RNONE));
        @(negedge clk);
        chk("w0_stall", 64'(stl[0]), 64'd0);
        chk("w0_mstat", 64'(mst[0]), 64'(SAOK));
        tick(0);

        drive(SAOK, IRMMOVQ, 64'd0, 64'h55, RNONE, RNONE);
        q.push_back(mk(SAOK, IRMMOVQ, 64'd0, '0, RNONE, RNONE));
        tick(0);

        drive(SAOK, IMRMOVQ, 64'd16, '0, RNONE, 4'd3);
        q.push_back(mk(SAOK, IMRMOVQ, 64'd16, 64'hDEAD, RNONE, 4'd3));
        @(negedge clk);
        chk("ld16_valM", valm[0], 64'hDEAD);
        chk("ld16_stall", 64'(stl[0]), 64'd0);
        tick(0);

        drive(SAOK, IMRMOVQ, 64'd1024, '0, RNONE, 4'd2);
        q.push_back(mk(SADR, IMRMOVQ, 64'd1024, '0, RNONE, 4'd2));
        @(negedge clk);
        chk("adr_mstat", 64'(mst[0]), 64'(SADR));
        chk("adr_valM", valm[0], 64'd0);
        chk("adr_stall", 64'(stl[0]), 64'd0);
        tick(0);

        drive(SAOK, IMRMOVQ, 64'd0, '0, RNONE, 4'd2);
        q.push_back(mk(SAOK, IMRMOVQ, 64'd0, 64'h55, RNONE, 4'd2));
        @(negedge clk);
        chk("nosticky_mstat", 64'(mst[0]), 64'(SAOK));
        chk("ld0_valM", valm[0], 64'h55);
        tick(0);

        drive(SAOK, IRMMOVQ, 64'd32, 64'h1111, RNONE, RNONE);
        q.push_back(mk(SAOK, IRMMOVQ, 64'd32, '0, RNONE, RNONE));
        tick(0);

        drive(SINS, IRMMOVQ, 64'd32, 64'h2222, RNONE, RNONE);
        q.push_back(mk(SINS, IRMMOVQ, 64'd32, '0, RNONE, RNONE));
        @(negedge clk);
        chk("sins_mstat", 64'(mst[0]), 64'(SINS));
        chk("sins_stall", 64'(stl[0]), 64'd0);
        tick(0);

        drive(SAOK, IMRMOVQ, 64'd32, '0, RNONE, 4'd6);
        q.push_back(mk(SAOK, IMRMOVQ, 64'd32, 64'h1111, RNONE, 4'd6));
        @(negedge clk);
        chk("sins_nowrite", valm[0], 64'h1111);
        tick(0);

        // W_stall holds the last loaded entry for three edges.
        drive(SAOK, IOPQ, 64'd99, '0, 4'd4, RNONE);
        W_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            q.push_back(mk(SAOK, IMRMOVQ, 64'd32, 64'h1111, RNONE, 4'd6));
            tick(0);
        end
        W_stall = 1'b0;
        W_bubble = 1'b1;
        q.push_back(bub());
        tick(0);
        W_bubble = 1'b0;

        // ---------------- WAIT_CYCLES = 2 ----------------
        do_reset(1);
        drive(SAOK, IPUSHQ, 64'd1000, 64'd7, 4'd4, RNONE);
        q.push_back(bub());
        q.push_back(bub());
        q.push_back(mk(SAOK, IPUSHQ, 64'd1000, '0, 4'd4, RNONE));
        @(negedge clk);
        chk("push_stall_c0", 64'(stl[1]), 64'd1);
        chk("w0_never_stall", 64'(stl[0]), 64'd0);
        tick(1);
        @(negedge clk);
        chk("push_stall_c1", 64'(stl[1]), 64'd1);
        tick(1);
        @(negedge clk);
        chk("push_stall_c2", 64'(stl[1]), 64'd0);
        tick(1);

        drive(SAOK, IPOPQ, 64'd1008, 64'd1000, 4'd4, 4'd5);
        q.push_back(bub());
        q.push_back(bub());
        q.push_back(mk(SAOK, IPOPQ, 64'd1008, 64'd7, 4'd4, 4'd5));
        @(negedge clk);
        chk("pop_stall_c0", 64'(stl[1]), 64'd1);
        chk("pop_valM_stalled", valm[1], 64'd0);
        tick(1);
        @(negedge clk);
        chk("pop_stall_c1", 64'(stl[1]), 64'd1);
        tick(1);
        @(negedge clk);
        chk("pop_stall_c2", 64'(stl[1]), 64'd0);
        chk("pop_valM", valm[1], 64'd7);
        tick(1);

        // ---------------- WAIT_CYCLES = 3 ----------------
        do_reset(2);
        drive(SAOK, IRMMOVQ, 64'd5, 64'hAA, RNONE, RNONE);
        for (int i = 0; i < 3; i++) q.push_back(bub());
        q.push_back(mk(SAOK, IRMMOVQ, 64'd5, '0, RNONE, RNONE));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("w3_stall", 64'(stl[2]), (i < 3) ? 64'd1 : 64'd0);
            tick(2);
        end

        // Second store to 5 is cut short by reset on its last cycle.
        drive(SAOK, IRMMOVQ, 64'd5, 64'hBB, RNONE, RNONE);
        for (int i = 0; i < 3; i++) begin
            q.push_back(bub());
            @(negedge clk);
            chk("abort_stall", 64'(stl[2]), 64'd1);
            tick(2);
        end
        rst = 1'b1;
        q.push_back(bub());
        tick(2);
        rst = 1'b0;
        drive(SAOK, INOP, '0, '0, RNONE, RNONE);
        @(negedge clk);
        chk("abort_stall_low", 64'(stl[2]), 64'd0);
        q.push_back(bub());
        tick(2);

        drive(SAOK, IMRMOVQ, 64'd5, '0, RNONE, 4'd1);
        for (int i = 0; i < 3; i++) q.push_back(bub());
        q.push_back(mk(SAOK, IMRMOVQ, 64'd5, 64'hAA, RNONE, 4'd1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rd5_stall", 64'(stl[2]), 64'd1);
            tick(2);
        end
        @(negedge clk);
        chk("rd5_stall_end", 64'(stl[2]), 64'd0);
        chk("abort_nowrite", valm[2], 64'hAA);
        tick(2);

        chk("sb_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
